// File: rtl/sc_pkg.sv
// Shared definitions for the bit-plane-counter stochastic number generator.
//   sng_state_e : run-control FSM states
//   bitrev      : reverses the low w bits of v (van der Corput ordering)
package sc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sng_state_e;

  // Width is passed as an argument so one function serves any group width.
  // Shifts are used instead of variable bit-selects to keep index widths clean.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w && ((v >> i) & 32'd1) != 32'd0) begin
        r = r | (32'd1 << (w - 1 - i));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/et_bpc_sng_if.sv
// Handshake / operand bus of the stochastic number generator.
//   start, len_log2, bxs, corr_mask : run request and its parameters
//   busy, xs, xs_valid, xs_ready    : stochastic bit stream with flow control
//   done, ones_cnt                  : end-of-run pulse and per-channel ones counts
// master = requester / consumer side, slave = generator side.
interface et_bpc_sng_if #(
  parameter int W = 4,
  parameter int N = 2,
  parameter int G = 2
);
  localparam int TW = W * G;
  localparam int LW = $clog2(TW + 1);

  logic                  start;
  logic [LW-1:0]         len_log2;
  logic [N*W-1:0]        bxs;
  logic [N-1:0]          corr_mask;
  logic                  busy;
  logic [N-1:0]          xs;
  logic                  xs_valid;
  logic                  xs_ready;
  logic                  done;
  logic [N*(TW+1)-1:0]   ones_cnt;

  modport master (
    output start, len_log2, bxs, corr_mask, xs_ready,
    input  busy, xs, xs_valid, done, ones_cnt
  );

  modport slave (
    input  start, len_log2, bxs, corr_mask, xs_ready,
    output busy, xs, xs_valid, done, ones_cnt
  );

endinterface

// File: rtl/et_bpc_counter.sv
// TW-bit transfer counter for the stochastic number generator.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (new run accepted)
//   en       : count one transfer
//   len      : run length exponent L (already clamped to TW)
//   cnt      : current transfer index
//   last     : cnt == 2^L-1, i.e. the current transfer ends the run
module et_bpc_counter #(
  parameter int TW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [LW-1:0] len,
  output logic [TW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TW'(1);
    end
  end

  // Mask of the low L bits; a shift by TW yields zero, so L=TW gives all ones
  // and the counter simply wraps to 0 on the final transfer.
  assign last = (cnt == ~({TW{1'b1}} << len));

endmodule

// File: rtl/et_bpc_sng.sv
// Early-terminating bit-plane-counter stochastic number generator.
// Latches N W-bit operands on start, then streams N stochastic bits per
// transfer for 2^min(len_log2,TW) transfers. Random values come from a
// TW-bit counter split into G bit-reversed W-bit groups.
//   clk, rst : clock, synchronous active-high reset (aborts a run, no done)
//   bus      : slave side of et_bpc_sng_if (start/params in, xs stream out,
//              done pulse and per-channel ones counts out)
module et_bpc_sng
  import sc_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 2,
  parameter int G = 2
) (
  input  logic          clk,
  input  logic          rst,
  et_bpc_sng_if.slave   bus
);

  localparam int TW = W * G;
  localparam int LW = $clog2(TW + 1);
  localparam int CW = TW + 1;

  sng_state_e         state;
  logic [N*W-1:0]     bx_reg;
  logic [N-1:0]       mask_reg;
  logic [LW-1:0]      len_reg;
  logic               done_reg;
  logic [N*CW-1:0]    ones_reg;

  logic               accept;
  logic               xfer;
  logic [LW-1:0]      len_clamped;
  logic [TW-1:0]      cnt;
  logic               last;
  logic [TW-1:0]      r_all;
  logic [N-1:0]       xs_int;

  assign accept      = (state == IDLE) && bus.start;
  assign xfer        = (state == RUN) && bus.xs_ready;
  assign len_clamped = (bus.len_log2 > LW'(TW)) ? LW'(TW) : bus.len_log2;

  et_bpc_counter #(
    .TW (TW),
    .LW (LW)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (xfer),
    .len  (len_reg),
    .cnt  (cnt),
    .last (last)
  );

  // One bit-reversed random value per group; group 0 sits on the counter LSBs
  // so it changes every transfer, higher groups change once per 2^(g*W).
  for (genvar gi = 0; gi < G; gi++) begin : g_rand
    assign r_all[gi*W +: W] = W'(bitrev(32'(cnt[gi*W +: W]), W));
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    localparam int GRP = gi % G;
    logic [W-1:0] r_sel;
    assign r_sel      = mask_reg[gi] ? r_all[0 +: W] : r_all[GRP*W +: W];
    assign xs_int[gi] = (r_sel < bx_reg[gi*W +: W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bx_reg   <= '0;
      mask_reg <= '0;
      len_reg  <= '0;
      done_reg <= 1'b0;
      ones_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bx_reg   <= bus.bxs;
            mask_reg <= bus.corr_mask;
            len_reg  <= len_clamped;
            ones_reg <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            for (int j = 0; j < N; j++) begin
              ones_reg[j*CW +: CW] <= ones_reg[j*CW +: CW] + CW'(xs_int[j]);
            end
            if (last) begin
              state    <= IDLE;
              done_reg <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.xs_valid = (state == RUN);
  assign bus.xs       = xs_int;
  assign bus.done     = done_reg;
  assign bus.ones_cnt = ones_reg;

endmodule

// File: tb/tb_et_bpc_sng.sv
// Self-checking bench for et_bpc_sng (W=4, N=2, G=2).
// Table-driven runs with hand-derived ones counts, hand sequences for
// ignored start, back-to-back start on done and mid-run reset, plus random
// runs checked against a behavioural model of the generator.
module tb_et_bpc_sng;

  localparam int W  = 4;
  localparam int N  = 2;
  localparam int G  = 2;
  localparam int TW = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  et_bpc_sng_if #(.W(W), .N(N), .G(G)) bus ();

  et_bpc_sng #(.W(W), .N(N), .G(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int bx0;
    int bx1;
    int mask;
    int rdy_rand;
    int exp_ones0;
    int exp_ones1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: transfer k uses k itself as the random-source word;
  // each channel picks its W-bit group, reverses it arithmetically and
  // compares against its operand.
  function automatic logic [1:0] model_xs(input int k, input int b0, input int b1, input int m);
    logic [1:0] res;
    int bxv[2];
    int grp;
    int v;
    int rev;
    bxv[0] = b0;
    bxv[1] = b1;
    res = '0;
    for (int j = 0; j < 2; j++) begin
      grp = (((m >> j) & 1) != 0) ? 0 : (j % G);
      v = (k >> (grp * W)) % 16;
      rev = 0;
      for (int i = 0; i < W; i++) begin
        if (((v >> i) & 1) != 0) rev += 1 << (W - 1 - i);
      end
      res[j] = (rev < bxv[j]);
    end
    return res;
  endfunction

  function automatic int ones_of(input int ch);
    logic [8:0] v;
    v = (ch == 0) ? bus.ones_cnt[8:0] : bus.ones_cnt[17:9];
    return int'(v);
  endfunction

  // One run: optionally issue start, then follow the stream until busy drops.
  // poke  : pulse start with different operands mid-run (must be ignored)
  // chain : raise start in the done cycle so the next run begins immediately
  // started : start was already raised by a chained predecessor
  task automatic run(input int len, input int b0, input int b1, input int m,
                     input int rdy_rand, input bit poke, input bit chain,
                     input bit started, output int o0, output int o1);
    int cyc;
    int xfers;
    int a0;
    int a1;
    int eff;
    logic [1:0] exp;
    logic [1:0] prev;
    bit stalled;
    bit rdy;
    eff = (len > TW) ? TW : len;
    if (!started) begin
      bus.len_log2  = 4'(len);
      bus.bxs       = {4'(b1), 4'(b0)};
      bus.corr_mask = 2'(m);
      bus.start     = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", int'(bus.busy), 1);
    chk("start_ones_clear", ones_of(0) + ones_of(1), 0);
    cyc = 0;
    xfers = 0;
    a0 = 0;
    a1 = 0;
    stalled = 1'b0;
    prev = '0;
    while (bus.busy && cyc < 2000) begin
      exp = model_xs(xfers, b0, b1, m);
      chk("xs", int'(bus.xs), int'(exp));
      chk("done_in_run", int'(bus.done), 0);
      if (stalled) chk("stall_hold", int'(bus.xs), int'(prev));
      prev = bus.xs;
      if (poke && cyc == 1) begin
        bus.start = 1'b1;
        bus.bxs   = ~bus.bxs;
      end else begin
        bus.start = 1'b0;
      end
      rdy = (rdy_rand == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.xs_ready = rdy;
      if (rdy) begin
        xfers++;
        a0 += int'(exp[0]);
        a1 += int'(exp[1]);
      end
      stalled = !rdy;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("timeout", int'(cyc >= 2000), 0);
    chk("xfers", xfers, 1 << eff);
    chk("done_pulse", int'(bus.done), 1);
    chk("valid_idle", int'(bus.xs_valid), 0);
    chk("ones0_model", ones_of(0), a0);
    chk("ones1_model", ones_of(1), a1);
    o0 = ones_of(0);
    o1 = ones_of(1);
    bus.xs_ready = 1'b1;
    $display("run len=%0d bx=%0d,%0d mask=%0d xfers=%0d ones=%0d,%0d",
             len, b0, b1, m, xfers, o0, o1);
    if (chain) begin
      bus.start = 1'b1;
    end else begin
      @(negedge clk);
      chk("done_width", int'(bus.done), 0);
      chk("ones_hold", ones_of(0), o0);
    end
  endtask

  initial begin
    int o0;
    int o1;
    int any_done;
    n_cmp = 0;
    n_bad = 0;

    //        len bx0 bx1 mask rdy  ones0 ones1
    vecs[0] = '{4,  5,  11, 0,   0,   5,    16};
    vecs[1] = '{8,  5,  11, 0,   0,   80,   176};
    vecs[2] = '{4,  3,  9,  3,   0,   3,    9};
    vecs[3] = '{0,  15, 0,  0,   0,   1,    0};
    vecs[4] = '{12, 15, 15, 0,   0,   240,  240};
    vecs[5] = '{2,  8,  4,  0,   0,   2,    4};
    vecs[6] = '{6,  15, 1,  2,   0,   60,   4};
    vecs[7] = '{4,  7,  7,  0,   1,   7,    16};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.len_log2 = '0;
    bus.bxs = '0;
    bus.corr_mask = '0;
    bus.xs_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.xs_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ones", ones_of(0) + ones_of(1), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].len, vecs[i].bx0, vecs[i].bx1, vecs[i].mask, vecs[i].rdy_rand,
          1'b0, 1'b0, 1'b0, o0, o1);
      chk($sformatf("vec%0d_ones0", i), o0, vecs[i].exp_ones0);
      chk($sformatf("vec%0d_ones1", i), o1, vecs[i].exp_ones1);
    end

    // start during RUN is ignored: operands and length stay as latched
    run(2, 5, 3, 0, 0, 1'b1, 1'b0, 1'b0, o0, o1);
    chk("poke_ones0", o0, 2);
    chk("poke_ones1", o1, 4);

    // start coincident with done starts the next run right away
    run(3, 9, 2, 0, 0, 1'b0, 1'b1, 1'b0, o0, o1);
    chk("chain_a_ones0", o0, 5);
    chk("chain_a_ones1", o1, 8);
    run(3, 9, 2, 0, 0, 1'b0, 1'b0, 1'b1, o0, o1);
    chk("chain_b_ones0", o0, 5);
    chk("chain_b_ones1", o1, 8);

    // random runs against the model
    for (int i = 0; i < 16; i++) begin
      run(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          1, 1'b0, 1'b0, 1'b0, o0, o1);
    end

    // reset during a run aborts it without done
    bus.len_log2  = 4'd4;
    bus.bxs       = {4'd9, 4'd7};
    bus.corr_mask = 2'b00;
    bus.xs_ready  = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.xs_valid), 0);
    chk("abort_ones", ones_of(0) + ones_of(1), 0);
    any_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) any_done = 1;
      @(negedge clk);
    end
    chk("abort_no_done", any_done, 0);
    $display("run reset-abort after 7 transfers busy=%0d ones=%0d,%0d",
             bus.busy, ones_of(0), ones_of(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
